// File: rtl/aregc01_seq.sv
// aregc01_seq: 1.8V core regulator power-up sequencer (in: clk, reset, req_en, pgood; out: reg_en, reg_enb, ready, fault, lockout, retry_cnt)
module aregc01_seq #(
  parameter int unsigned SETTLE_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 256,
  parameter int unsigned COOLDOWN_CYCLES = 64,
  parameter int unsigned DEGLITCH        = 4,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_en,
  input  logic       pgood,
  output logic       reg_en,
  output logic       reg_enb,
  output logic       ready,
  output logic       fault,
  output logic       lockout,
  output logic [1:0] retry_cnt
);
  localparam int unsigned GW = $clog2(DEGLITCH + 1);
  typedef enum logic [2:0] {OFF, START, CHECK, ON, FLT, LOCK} state_t;
  state_t state, nxt;
  logic pg_m, pg_s;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0] glitch, glitch_nxt;
  logic [1:0] retry_nxt;
  logic settle_done, timeout, cool_done, brown, en_nxt;
  assign settle_done = cnt == CNT_W'(SETTLE_CYCLES - 1);
  assign timeout     = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign cool_done   = cnt == CNT_W'(COOLDOWN_CYCLES - 1);
  assign glitch_nxt  = pg_s ? '0 : glitch + 1'b1;
  assign brown       = glitch_nxt == GW'(DEGLITCH);
  assign en_nxt      = nxt inside {START, CHECK, ON};
  always_comb begin
    nxt = state;
    if (!req_en) nxt = OFF;
    else
      case (state)
        OFF:     nxt = START;
        START:   nxt = settle_done ? CHECK : START;
        CHECK:   nxt = pg_s ? ON : timeout ? FLT : CHECK;
        ON:      nxt = brown ? FLT : ON;
        FLT:     nxt = !cool_done ? FLT : (retry_cnt < 2'(MAX_RETRY)) ? START : LOCK;
        default: nxt = LOCK;
      endcase
    retry_nxt = nxt == OFF ? 2'd0 : (state == FLT && nxt == START) ? retry_cnt + 2'd1 : retry_cnt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OFF;
      pg_m      <= 1'b0;
      pg_s      <= 1'b0;
      cnt       <= '0;
      glitch    <= '0;
      retry_cnt <= 2'd0;
      reg_en    <= 1'b0;
      reg_enb   <= 1'b1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      pg_m      <= pgood;
      pg_s      <= pg_m;
      state     <= nxt;
      cnt       <= (nxt == state && nxt inside {START, CHECK, FLT}) ? cnt + 1'b1 : '0;
      glitch    <= (nxt == ON && state == ON) ? glitch_nxt : '0;
      retry_cnt <= retry_nxt;
      reg_en    <= en_nxt;
      reg_enb   <= !en_nxt;
      ready     <= nxt == ON;
      fault     <= nxt inside {FLT, LOCK};
      lockout   <= nxt == LOCK;
    end
  end
endmodule

// File: tb/tb_aregc01_seq.sv
// tb_aregc01_seq: directed self-checking bench for the regulator power-up sequencer
module tb_aregc01_seq;
  logic clk = 1'b0, reset = 1'b1, req_en = 1'b0, pgood = 1'b1;
  logic reg_en, reg_enb, ready, fault, lockout;
  logic [1:0] retry_cnt;
  int n_cmp = 0, n_err = 0;
  aregc01_seq dut (
    .clk(clk), .reset(reset), .req_en(req_en), .pgood(pgood),
    .reg_en(reg_en), .reg_enb(reg_enb), .ready(ready), .fault(fault),
    .lockout(lockout), .retry_cnt(retry_cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic look(input string tag, input logic e_en, input logic e_rdy, input logic e_flt, input logic e_lk, input logic [1:0] e_rc);
    chk(tag, {25'd0, reg_en, reg_enb, ready, fault, lockout, retry_cnt},
             {25'd0, e_en, !e_en, e_rdy, e_flt, e_lk, e_rc});
  endtask
  initial begin
    step(3);
    look("reset_state", 0, 0, 0, 0, 2'd0);
    reset = 1'b0;
    step(3);
    look("idle_off", 0, 0, 0, 0, 2'd0);
    req_en = 1'b1;
    step(1);
    look("nom_en_edge0", 1, 0, 0, 0, 2'd0);
    step(16);
    look("nom_check_edge16", 1, 0, 0, 0, 2'd0);
    step(1);
    look("nom_ready_edge17", 1, 1, 0, 0, 2'd0);
    pgood = 1'b0;
    step(3);
    pgood = 1'b1;
    step(10);
    look("glitch3_ignored", 1, 1, 0, 0, 2'd0);
    pgood = 1'b0;
    step(5);
    look("brown_pre", 1, 1, 0, 0, 2'd0);
    step(1);
    look("brown_fault", 0, 0, 1, 0, 2'd0);
    pgood = 1'b1;
    step(63);
    look("brown_cool", 0, 0, 1, 0, 2'd0);
    step(1);
    look("brown_retry1", 1, 0, 0, 0, 2'd1);
    step(17);
    look("retry_on_keeps_cnt", 1, 1, 0, 0, 2'd1);
    req_en = 1'b0;
    step(1);
    look("off_clears_retry", 0, 0, 0, 0, 2'd0);
    pgood = 1'b0;
    step(3);
    req_en = 1'b1;
    step(1);
    look("to_en_edge0", 1, 0, 0, 0, 2'd0);
    step(271);
    look("to_check_last", 1, 0, 0, 0, 2'd0);
    step(1);
    look("to_fault1", 0, 0, 1, 0, 2'd0);
    step(63);
    look("to_cool1", 0, 0, 1, 0, 2'd0);
    step(1);
    look("to_retry1", 1, 0, 0, 0, 2'd1);
    step(272);
    look("to_fault2", 0, 0, 1, 0, 2'd1);
    step(64);
    look("to_retry2", 1, 0, 0, 0, 2'd2);
    step(272);
    look("to_fault3", 0, 0, 1, 0, 2'd2);
    step(64);
    look("to_retry3", 1, 0, 0, 0, 2'd3);
    step(272);
    look("to_fault4", 0, 0, 1, 0, 2'd3);
    step(63);
    look("to_cool4", 0, 0, 1, 0, 2'd3);
    step(1);
    look("lockout", 0, 0, 1, 1, 2'd3);
    step(5);
    look("lockout_hold", 0, 0, 1, 1, 2'd3);
    req_en = 1'b0;
    step(1);
    look("lockout_exit", 0, 0, 0, 0, 2'd0);
    req_en = 1'b1;
    step(1 + 272 + 64);
    look("abortf_retry1", 1, 0, 0, 0, 2'd1);
    step(272);
    look("abortf_fault", 0, 0, 1, 0, 2'd1);
    step(10);
    req_en = 1'b0;
    step(1);
    look("abortf_off", 0, 0, 0, 0, 2'd0);
    req_en = 1'b1;
    step(1);
    step(269);
    pgood = 1'b1;
    step(2);
    look("late_pg_pre", 1, 0, 0, 0, 2'd0);
    step(1);
    look("late_pg_on", 1, 1, 0, 0, 2'd0);
    req_en = 1'b0;
    step(1);
    look("late_pg_off", 0, 0, 0, 0, 2'd0);
    pgood = 1'b0;
    step(3);
    req_en = 1'b1;
    step(1);
    step(271);
    look("abort_to_pre", 1, 0, 0, 0, 2'd0);
    req_en = 1'b0;
    step(1);
    look("abort_to_off", 0, 0, 0, 0, 2'd0);
    pgood = 1'b1;
    step(3);
    req_en = 1'b1;
    step(18);
    look("rst_pre_on", 1, 1, 0, 0, 2'd0);
    #2;
    reset = 1'b1;
    req_en = 1'b0;
    #1;
    look("rst_async", 0, 0, 0, 0, 2'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(3);
    look("rst_release_off", 0, 0, 0, 0, 2'd0);
    req_en = 1'b1;
    step(1);
    look("rst_restart", 1, 0, 0, 0, 2'd0);
    step(17);
    look("rst_restart_on", 1, 1, 0, 0, 2'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/aregc01_seq.md
Name: aregc01_seq

Overview:
- Digital power-up sequencer sitting directly upstream of the 1.8 V core regulator; drives the regulator's EN/ENB pins.
- On a software/pad enable request it:
  - turns the regulator on;
  - waits a fixed soft-start settle time;
  - confirms a power-good comparator indication within a timeout;
  - holds the rail while power-good remains valid.
- Faults (timeout or brown-out) disable the regulator, cool down, retry a bounded number of times, then lock out.

Parameters:
- SETTLE_CYCLES, 16, cycles EN is held before power-good is examined (>=1)
- TIMEOUT_CYCLES, 256, max cycles in CHECK waiting for power-good (>=1)
- COOLDOWN_CYCLES, 64, cycles EN is held low in FAULT before a retry (>=1)
- DEGLITCH, 4, consecutive synchronized-low pgood samples in ON that constitute a brown-out (>=1)
- MAX_RETRY, 3, retries permitted after the first attempt (0..3)
- CNT_W, 10, width of the shared delay counter; must hold max(SETTLE, TIMEOUT, COOLDOWN)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_en  input  1  enable request, synchronous to clk
- pgood  input  1  asynchronous power-good from regulator output comparator
- reg_en  output  1  regulator EN
- reg_enb  output  1  regulator ENB, always the complement of reg_en
- ready  output  1  rail up and valid (state ON)
- fault  output  1  state FAULT or LOCKOUT
- lockout  output  1  retries exhausted (state LOCKOUT)
- retry_cnt  output  2  retries consumed in the current request

Behaviour:
- Reset (async assert, sync release) values:
  - state OFF; reg_en=0, reg_enb=1, ready=0, fault=0, lockout=0, retry_cnt=0;
  - delay counter 0; pgood synchronizer 0.
- All outputs are registered, decoded from the next state, so they change on the same edge as the state.
- pgood passes through a 2-flop synchronizer (pg_s). A pgood change is visible to the FSM 2 cycles later.
- States and transitions (counter cnt reloads to 0 on every state entry):
  - OFF: reg_en=0. If req_en=1, go to START.
  - START: reg_en=1. Count cnt up to SETTLE_CYCLES-1, then go to CHECK. pg_s is ignored in START.
  - CHECK: reg_en=1.
    - If pg_s=1, go to ON.
    - Else if cnt=TIMEOUT_CYCLES-1, go to FAULT.
    - pg_s=1 on the final timeout cycle wins: go to ON.
  - ON: reg_en=1, ready=1.
    - Maintain a glitch counter of consecutive pg_s=0 samples; it clears on any pg_s=1.
    - When the glitch count reaches DEGLITCH, go to FAULT.
  - FAULT: reg_en=0, fault=1. When cnt=COOLDOWN_CYCLES-1:
    - if retry_cnt<MAX_RETRY: retry_cnt+=1, go to START;
    - else go to LOCKOUT.
  - LOCKOUT: reg_en=0, fault=1, lockout=1. Stay until req_en=0, then go to OFF.
- req_en=0 in START, CHECK, ON or FAULT: go to OFF on the next edge. This overrides all other transitions, including simultaneous timeout or deglitch expiry.
- retry_cnt clears to 0 on entry to OFF, not on entry to ON.
- retry_cnt saturates at MAX_RETRY and never wraps.
- The counter never wraps: each terminal compare forces a state exit.
- Overall latency, req_en=1 sampled at edge N with pgood already high:
  - reg_en=1 after edge N;
  - CHECK entered at edge N+SETTLE_CYCLES;
  - ready=1 after edge N+SETTLE_CYCLES+1.
- reset asserted mid-operation forces reg_en=0 immediately (asynchronously), with all state cleared.
- reg_enb is never equal to reg_en, including during reset.

Test Plan:
- Nominal power-up: reset 3 cycles, pgood=1 held, req_en=1 at edge 0 -> reg_en=1 after edge 0; ready=1 after edge 17 (defaults); fault=0; retry_cnt=0.
- Timeout and retry: pgood=0 held, req_en=1 ->
  - first reg_en fall after 16+256 cycles in EN;
  - EN low for 64 cycles, retry_cnt=1, EN high again;
  - after 3 retries, lockout=1, reg_en=0;
  - req_en=0 then returns to OFF with retry_cnt=0.
- Brown-out deglitch in ON:
  - pgood low for 3 cycles then high -> ready stays 1;
  - pgood low for 4+ cycles -> fault=1, reg_en=0 exactly DEGLITCH cycles after pg_s first goes low.
- Late power-good: pgood rises so pg_s=1 on cycle TIMEOUT_CYCLES-1 of CHECK -> ON, no fault.
- Abort: req_en dropped on the same edge CHECK times out -> OFF, fault=0. Also drop req_en in FAULT -> OFF, retry_cnt=0.
- Async reset mid-ON: assert reset between clock edges -> reg_en=0, reg_enb=1 before the next edge. On release, state is OFF; the sequence restarts only when req_en is sampled high.
